// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : shared arbiter state encoding and bus-error read pattern
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : fetch, data and memory handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              bus_err;

  // Arbiter side
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr,
           mem_wdata, bus_err
  );

  // Requesters and memory side
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr,
           mem_wdata, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_starve_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_starve_counter : two-way grant select with saturating starvation count
// Rev 1.0
// ---------------------------------------------------------------------------
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic grant_if_o,
  output logic grant_d_o
);
  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Data normally wins; fetch wins when alone or once it has waited long enough
  always_comb begin
    grant_if_o = if_req_i && (!d_req_i || (cnt_q == LIMIT));
    grant_d_o  = d_req_i && !grant_if_o;
    cnt_d      = cnt_q;
    if (sample_i) begin
      if (!if_req_i || grant_if_o) begin
        cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one variable-latency memory between fetch and data
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              we_q, we_d;
  logic              owner_d_q, owner_d_d;
  logic              err_q, err_d;
  logic              grant_if, grant_d;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .sample_i  (state_q == ST_IDLE),
    .if_req_i  (bus.if_req),
    .d_req_i   (bus.d_req),
    .grant_if_o(grant_if),
    .grant_d_o (grant_d)
  );

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    owner_d_d  = owner_d_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (grant_if) begin
          state_d   = ST_BUSY_I;
          addr_d    = bus.if_addr;
          we_d      = 1'b0;
          owner_d_d = 1'b0;
        end else if (grant_d) begin
          state_d   = ST_BUSY_D;
          addr_d    = bus.d_addr;
          wdata_d   = bus.d_wdata;
          we_d      = bus.d_we;
          owner_d_d = 1'b1;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.mem_ack || (tmo_q == TO_LAST)) begin
          state_d = ST_RESP;
          err_d   = !bus.mem_ack;
          // A late ack on the final cycle still wins over the timeout
          if (state_q == ST_BUSY_I) begin
            if_rdata_d = bus.mem_ack ? bus.mem_rdata : BUS_ERR_DATA;
          end else if (!we_q) begin
            d_rdata_d = bus.mem_ack ? bus.mem_rdata : BUS_ERR_DATA;
          end
        end
      end
      ST_RESP: begin
        tmo_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_d_q  <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      owner_d_q  <= owner_d_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_en    = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign bus.mem_we    = (state_q == ST_BUSY_D) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ready  = (state_q == ST_RESP) && !owner_d_q;
  assign bus.d_ready   = (state_q == ST_RESP) && owner_d_q;
  assign bus.bus_err   = (state_q == ST_RESP) && err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed and random checks against a transaction model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import cpu_pkg::*;

  localparam int ADDR_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory environment
  logic [31:0] mem [logic [31:0]];
  int  lat_left  = -1;
  int  force_lat = -1;
  bit  hang      = 1'b0;
  bit  stray_en  = 1'b0;
  bit  prev_en   = 1'b0;
  int  en_cycles = 0;
  bit  order[$];

  // Transaction-level reference model
  bit          m_busy, m_resp, m_err, m_owner_d, m_we;
  int          m_cnt, m_starve;
  logic [31:0] m_addr, m_wdata, e_if_rdata, e_d_rdata;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic pif, pd, pwe, prst, pack;
    logic [31:0] pia, pda, pwd, prd;
    pif = bus.if_req;  pia = bus.if_addr;
    pd  = bus.d_req;   pda = bus.d_addr;  pwe = bus.d_we;  pwd = bus.d_wdata;
    pack = bus.mem_ack; prd = bus.mem_rdata; prst = reset;
    @(posedge clk);
    #1;
    if (prst) begin
      m_busy = 0; m_resp = 0; m_err = 0; m_starve = 0;
      e_if_rdata = '0; e_d_rdata = '0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      m_cnt++;
      if (pack || m_cnt == TIMEOUT) begin
        m_busy = 0; m_resp = 1; m_err = !pack;
        if (!m_owner_d) e_if_rdata = pack ? prd : BUS_ERR_DATA;
        else if (!m_we) e_d_rdata = pack ? prd : BUS_ERR_DATA;
      end
    end else begin
      if (!pif) m_starve = 0;
      if (pif && (!pd || m_starve == STARVE_LIMIT)) begin
        m_busy = 1; m_cnt = 0; m_owner_d = 0; m_we = 0; m_addr = pia; m_starve = 0;
      end else if (pd) begin
        m_busy = 1; m_cnt = 0; m_owner_d = 1; m_we = pwe; m_addr = pda; m_wdata = pwd;
        if (pif && m_starve < STARVE_LIMIT) m_starve++;
      end
    end

    chk("mem_en", {31'b0, bus.mem_en}, {31'b0, m_busy});
    chk("if_ready", {31'b0, bus.if_ready}, {31'b0, m_resp && !m_owner_d});
    chk("d_ready", {31'b0, bus.d_ready}, {31'b0, m_resp && m_owner_d});
    chk("bus_err", {31'b0, bus.bus_err}, {31'b0, m_resp && m_err});
    chk("if_rdata", bus.if_rdata, e_if_rdata);
    chk("d_rdata", bus.d_rdata, e_d_rdata);
    chk("one_ready", {31'b0, bus.if_ready & bus.d_ready}, 32'd0);
    if (m_busy) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, m_owner_d && m_we});
      if (m_owner_d && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (bus.if_ready) order.push_back(1'b1);
    else if (bus.d_ready) order.push_back(1'b0);
    if (bus.mem_en) en_cycles++;

    if (bus.mem_en) begin
      if (!prev_en) lat_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      if (!hang && lat_left == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_rd(bus.mem_addr);
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        lat_left = -1;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        if (lat_left > 0) lat_left--;
      end
    end else begin
      bus.mem_ack   = stray_en && ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
    end
    prev_en = bus.mem_en;
  endtask

  task automatic wait_ready(input bit want_d, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(want_d ? bus.d_ready : bus.if_ready) && n < 200);
    chk(want_d ? "d_ready_seen" : "if_ready_seen",
        {31'b0, want_d ? bus.d_ready : bus.if_ready}, 32'd1);
  endtask

  initial begin
    int n;
    bit exp_ord[10];
    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    step();
    step();
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    reset = 1'b0;
    step();

    // Single fetch, ack two cycles after mem_en
    mem[32'h0040_0000] = 32'h2008_0005;
    force_lat = 2;
    bus.if_req = 1; bus.if_addr = 32'h0040_0000;
    wait_ready(0, n);
    chk("fetch_latency", n, 32'd4);
    chk("fetch_rdata", bus.if_rdata, 32'h2008_0005);
    bus.if_req = 0;
    step();

    // Data write then read-back, immediate ack
    force_lat = 0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1001_0000; bus.d_wdata = 32'h0000_ABCD;
    wait_ready(1, n);
    chk("wr_latency", n, 32'd2);
    chk("wr_rdata_kept", bus.d_rdata, 32'd0);
    chk("wr_mem", mem_rd(32'h1001_0000), 32'h0000_ABCD);
    bus.d_we = 0;
    wait_ready(1, n);
    chk("rd_rdata", bus.d_rdata, 32'h0000_ABCD);
    bus.d_req = 0;
    step();

    // Contention: fetch yields to data STARVE_LIMIT times, then wins
    exp_ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    order.delete();
    bus.if_req = 1; bus.d_req = 1; bus.d_we = 0;
    for (int k = 0; k < 100 && order.size() < 10; k++) begin
      step();
      if (bus.if_ready) bus.if_addr = 32'h0040_0000 + (32'($urandom_range(0, 15)) << 2);
      if (bus.d_ready)  bus.d_addr  = 32'h1001_0000 + (32'($urandom_range(0, 7)) << 2);
    end
    bus.if_req = 0; bus.d_req = 0;
    chk("grant_count", order.size(), 32'd10);
    for (int k = 0; k < 10; k++) chk("grant_order", {31'b0, order[k]}, {31'b0, exp_ord[k]});
    repeat (4) step();

    // Timeout with a fetch waiting behind it
    hang = 1; en_cycles = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1002_0000;
    bus.if_req = 1; bus.if_addr = 32'h0040_0010;
    wait_ready(1, n);
    chk("tmo_latency", n, 32'd65);
    chk("tmo_en_cycles", en_cycles, 32'd64);
    chk("tmo_bus_err", {31'b0, bus.bus_err}, 32'd1);
    chk("tmo_rdata", bus.d_rdata, BUS_ERR_DATA);
    hang = 0; force_lat = 1; bus.d_req = 0;
    wait_ready(0, n);
    chk("post_tmo_fetch", bus.if_rdata, mem_rd(32'h0040_0010));
    chk("post_tmo_no_err", {31'b0, bus.bus_err}, 32'd0);
    bus.if_req = 0;
    step();

    // Reset during BUSY_D with a late ack; starvation count must restart
    bus.d_req = 1; bus.if_req = 1;
    step();
    step();
    chk("busy_before_rst", {31'b0, bus.mem_en}, 32'd1);
    reset = 1'b1;
    step();
    chk("rst_mid_en", {31'b0, bus.mem_en}, 32'd0);
    chk("rst_mid_dready", {31'b0, bus.d_ready}, 32'd0);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    order.delete();
    for (int k = 0; k < 100 && order.size() < 5; k++) step();
    bus.if_req = 0; bus.d_req = 0;
    chk("rst_grant_count", order.size(), 32'd5);
    for (int k = 0; k < 5; k++) chk("rst_grant_order", {31'b0, order[k]}, {31'b0, exp_ord[k]});
    repeat (4) step();

    // Stray ack while idle
    bus.mem_ack = 1'b1;
    step();
    chk("stray_en", {31'b0, bus.mem_en}, 32'd0);
    chk("stray_ready", {31'b0, bus.if_ready | bus.d_ready}, 32'd0);
    step();

    // Request dropped mid-transaction still completes
    force_lat = 3;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1003_0000;
    step();
    step();
    bus.d_req = 0;
    wait_ready(1, n);
    chk("drop_rdata", bus.d_rdata, mem_rd(32'h1003_0000));
    step();

    // Random traffic with random latency and stray acks
    force_lat = -1; stray_en = 1;
    for (int c = 0; c < 400; c++) begin
      step();
      if (bus.if_ready || !bus.if_req) begin
        bus.if_req  = 1'($urandom_range(0, 1));
        bus.if_addr = 32'h0040_0000 + (32'($urandom_range(0, 15)) << 2);
      end
      if (bus.d_ready || !bus.d_req) begin
        bus.d_req   = 1'($urandom_range(0, 1));
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = 32'h1001_0000 + (32'($urandom_range(0, 7)) << 2);
        bus.d_wdata = $urandom;
      end
    end
    bus.if_req = 0; bus.d_req = 0; stray_en = 0;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
